regfile_writeback_unit: RTL
===========================

Name: regfile_writeback_unit

Overview:
- Write-side front end for the 32-entry general-purpose register file.
- Collects destination-register results from two producers, the ALU and the load/memory unit, over valid/ready handshakes.
- Queues results in order in a small FIFO and drives the register file's single write port (we/write_addr/write_data), at most one write per cycle.
- Exposes a pending-write mask so issue logic can detect RAW hazards against results not yet committed.

Parameters:
- DATA_WIDTH, 32, width of result data and rf_wdata.
- ADDR_WIDTH, 5, register index width; the mask width is 2**ADDR_WIDTH.
- FIFO_DEPTH, 4, number of queued results; must be a power of two, at least 2.
- DISCARD_R0, 1, when 1, results targeting register 0 are accepted but never enqueued or written.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- alu_valid  in  1  ALU result valid.
- alu_ready  out  1  unit accepts the ALU result this cycle.
- alu_rd  in  ADDR_WIDTH  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- mem_valid  in  1  load result valid.
- mem_ready  out  1  unit accepts the load result this cycle.
- mem_rd  in  ADDR_WIDTH  load destination register.
- mem_data  in  DATA_WIDTH  load result.
- rf_stall  in  1  write port borrowed (for example by debug); no commit this cycle.
- rf_we  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register file write address (registered).
- rf_wdata  out  DATA_WIDTH  register file write data (registered).
- pending_mask  out  2**ADDR_WIDTH  bit i=1 if a queued or currently driven write targets register i.
- fifo_count  out  log2(FIFO_DEPTH)+1  number of entries currently queued.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - Clears read/write pointers and count.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pending_mask=0, fifo_count=0.
  - Queued entries and any write being driven are dropped.
  - alu_ready=0 and mem_ready=0 while rst_n=0.
- Acceptance (at most one result per cycle):
  - mem_ready = rst_n && (count < FIFO_DEPTH).
  - alu_ready = rst_n && (count < FIFO_DEPTH) && !mem_valid. The load unit has fixed priority.
  - A transfer occurs at an edge where valid && ready. A producer holds valid/rd/data stable until its transfer.
  - ready does not depend on a same-cycle pop, so there is no combinational path from rf_stall to ready.
- Enqueue:
  - An accepted result is written to FIFO[wptr] and wptr increments modulo FIFO_DEPTH.
  - If DISCARD_R0=1 and rd==0, the handshake still completes but nothing is enqueued.
- Commit:
  - At each edge with count>0 and rf_stall=0: pop the head into rf_waddr/rf_wdata, set rf_we=1, and increment rptr modulo FIFO_DEPTH.
  - Otherwise rf_we=0; rf_waddr and rf_wdata hold their previous values.
  - The register file captures the write on the following edge.
- Latency:
  - Result accepted at edge N, FIFO empty, no stall: rf_we=1 during cycle N+1 to N+2, and the register file updates at edge N+2.
  - Each stalled cycle adds one cycle.
- Simultaneous push and pop: count is unchanged. Wrap-around is handled by the pointers; the full/empty distinction uses count.
- Ordering:
  - Commits occur strictly in acceptance order, so successive writes to the same rd commit in order and the last write wins.
  - No merging or bypassing of queued entries.
- pending_mask:
  - Combinational OR of the one-hot rd of every valid FIFO entry, plus rf_waddr when rf_we=1.
  - Bit 0 is never set when DISCARD_R0=1.
- Throughput: sustained 1 write/cycle with no stall. With FIFO_DEPTH full, ready stays low until a pop frees a slot, which is visible the cycle after the pop edge.
- Reset mid-operation: takes priority over push and pop at the same edge.

Test Plan:
- Single ALU result alu_rd=5, alu_data=0xDEADBEEF at edge N, no stall -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1; pending_mask[5]=1 from N until the rf_we cycle ends.
- mem_valid and alu_valid both high (mem_rd=3, alu_rd=4) -> alu_ready=0 and mem is accepted first; the ALU result is accepted the next cycle; commits are r3 then r4 on consecutive cycles.
- rf_stall=1 held for 6 cycles while pushing 5 ALU results (rd 1..5) -> fifo_count reaches 4 and alu_ready=0 with the 5th held; after the stall is released, commits are 1,2,3,4,5 in order with no loss.
- DISCARD_R0=1, alu_rd=0, data=0x1234 -> alu_ready=1 and the handshake completes; rf_we stays 0, fifo_count stays 0, pending_mask=0.
- Two back-to-back writes to rd=7 (0x1, then 0x2) -> commits 0x1 then 0x2; pending_mask[7] stays 1 until the second commit cycle ends.
- rst_n=0 asserted with 3 entries queued and rf_we=1 -> after the edge rf_we=0, fifo_count=0, pending_mask=0; no further writes occur after rst_n returns to 1.

Source files
------------

// File: rtl/regfile_writeback_unit.sv
// Write-side front end for the register file: merges ALU and load results into
// an in-order FIFO and drains it through the single registered write port.
module regfile_writeback_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int DISCARD_R0 = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [ADDR_WIDTH-1:0]     alu_rd,
  input  logic [DATA_WIDTH-1:0]     alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [ADDR_WIDTH-1:0]     mem_rd,
  input  logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      rf_stall,
  output logic                      rf_we,
  output logic [ADDR_WIDTH-1:0]     rf_waddr,
  output logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic [(1<<ADDR_WIDTH)-1:0] pending_mask,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NUM_REGS = 1 << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      count;

  logic                  not_full;
  logic                  mem_fire;
  logic                  alu_fire;
  logic [ADDR_WIDTH-1:0] in_rd;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  drop_r0;
  logic                  push;
  logic                  pop;
  logic [PTR_W-1:0]      idx;
  logic [NUM_REGS-1:0]   mask;

  // Readiness looks only at the registered count, so rf_stall never reaches ready.
  assign not_full  = (count < DEPTH_C);
  assign mem_ready = rst_n && not_full;
  assign alu_ready = rst_n && not_full && !mem_valid;

  assign mem_fire = mem_valid && mem_ready;
  assign alu_fire = alu_valid && alu_ready;
  assign in_rd    = mem_fire ? mem_rd   : alu_rd;
  assign in_data  = mem_fire ? mem_data : alu_data;
  assign drop_r0  = (DISCARD_R0 != 0) && (in_rd == '0);
  assign push     = (mem_fire || alu_fire) && !drop_r0;
  assign pop      = (count != '0) && !rf_stall;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr]   <= in_rd;
      fifo_data[wptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rf_we    <= 1'b1;
        rf_waddr <= fifo_rd[rptr];
        rf_wdata <= fifo_data[rptr];
        rptr     <= rptr + 1'b1;
      end else begin
        rf_we <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Only the count entries starting at rptr are live; stale slots are ignored.
  always_comb begin
    mask = '0;
    idx  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rptr + PTR_W'(i);
      if (CNT_W'(i) < count) begin
        mask[fifo_rd[idx]] = 1'b1;
      end
    end
    if (rf_we) begin
      mask[rf_waddr] = 1'b1;
    end
  end

  assign pending_mask = mask;
  assign fifo_count   = count;

endmodule
